// File: rtl/kf_seq_pkg.sv
// Shared constants for the multi-channel Kalman frame sequencer:
// stage indices/offsets, state-word field layout and reset pattern.
package kf_seq_pkg;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } seq_state_t;

    localparam int NSTG    = 8;
    localparam int STG_PS  = 0;
    localparam int STG_PC  = 1;
    localparam int STG_Z   = 2;
    localparam int STG_KG  = 3;
    localparam int STG_Q   = 4;
    localparam int STG_R   = 5;
    localparam int STG_PST = 6;
    localparam int STG_POC = 7;

    localparam int OFF_PS   = 0;
    localparam int OFF_PC   = 0;
    localparam int OFF_Z    = 8;
    localparam int OFF_KG   = 10;
    localparam int OFF_Q    = 10;
    localparam int OFF_R    = 12;
    localparam int OFF_TAIL = 9;

    // Field index f occupies bits [f*N +: N] of the packed state word.
    localparam int NFLD    = 12;
    localparam int FLD_P11 = 0;
    localparam int FLD_P10 = 1;
    localparam int FLD_P01 = 2;
    localparam int FLD_P00 = 3;
    localparam int FLD_Q22 = 4;
    localparam int FLD_Q21 = 5;
    localparam int FLD_Q12 = 6;
    localparam int FLD_Q11 = 7;
    localparam int FLD_R22 = 8;
    localparam int FLD_R21 = 9;
    localparam int FLD_R12 = 10;
    localparam int FLD_R11 = 11;

    localparam logic [NFLD-1:0] ONE_MASK = 12'b1001_1001_1001;

    localparam int          DEF_FRAC = 8;
    localparam int unsigned ONE      = 32'd1 << DEF_FRAC;
    localparam int          MAX_W    = NFLD * 64;

    function automatic int stg_off(input int idx, input int fc);
        case (idx)
            STG_PS:  return OFF_PS;
            STG_PC:  return OFF_PC;
            STG_Z:   return OFF_Z;
            STG_KG:  return OFF_KG;
            STG_Q:   return OFF_Q;
            STG_R:   return OFF_R;
            default: return fc - OFF_TAIL;
        endcase
    endfunction

    function automatic logic [MAX_W-1:0] rst_pattern(input int n,
                                                     input int frac);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int f = 0; f < NFLD; f++) begin
            if (ONE_MASK[f])
                r = r | (MAX_W'(1) << (f * n + frac));
        end
        return r;
    endfunction

endpackage

// File: rtl/kf_state_bank.sv
// Per-channel filter state registers: one write port, one clear port,
// combinational read. Clear has priority over a same-channel write.
module kf_state_bank
    import kf_seq_pkg::*;
#(
    parameter int N    = 16,
    parameter int FRAC = 8,
    parameter int NCH  = 4,
    parameter int CH_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [12*N-1:0]   wr_data,
    input  logic              clr,
    input  logic [CH_W-1:0]   clr_ch,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [12*N-1:0]   rd_data
);

    localparam int W = 12 * N;
    localparam logic [W-1:0] RST = W'(rst_pattern(N, FRAC));

    logic [W-1:0] bank [NCH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++)
                bank[i] <= RST;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr && clr_ch == CH_W'(i))
                    bank[i] <= RST;
                else if (we && wr_ch == CH_W'(i))
                    bank[i] <= wr_data;
            end
        end
    end

    // Out-of-range channels read back the reset pattern.
    always_comb begin
        rd_data = RST;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == CH_W'(i))
                rd_data = bank[i];
        end
    end

endmodule

// File: rtl/kf_frame_seq_mc.sv
// Multi-channel Kalman frame sequencer: stage pulses, commit, abort.
// Define KF_SEQ_BACK2BACK_EN to accept a new frame on the commit cycle.
module kf_frame_seq_mc
    import kf_seq_pkg::*;
#(
    parameter  int N            = 16,
    parameter  int FRAC         = 8,
    parameter  int NCH          = 4,
    parameter  int FRAME_CYCLES = 36,
    localparam int CH_W         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              ch_clr,
    input  logic [CH_W-1:0]   ch_clr_id,
    input  logic              abort,
    output logic [7:0]        stg_start,
    output logic [CH_W-1:0]   cur_ch,
    input  logic [12*N-1:0]   nxt_state,
    output logic [12*N-1:0]   prv_state,
    output logic              done,
    output logic [CH_W-1:0]   done_ch,
    output logic              busy
);

    localparam int CYC_W = 6;

`ifdef KF_SEQ_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    seq_state_t       state;
    logic [CYC_W-1:0] cyc;
    logic             run;
    logic             last;
    logic             accept;
    logic             ch_ok;

    assign run    = (state == S_RUN);
    assign last   = run && (cyc == CYC_W'(FRAME_CYCLES - 1));
    assign done   = last && !abort;
    assign ch_ok  = (32'(cur_ch) < NCH);
    assign busy   = run;
    assign accept = in_valid && in_ready;

    assign in_ready = !run || (B2B && done);
    assign done_ch  = done ? cur_ch : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cyc    <= '0;
            cur_ch <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        state  <= S_RUN;
                        cyc    <= '0;
                        cur_ch <= in_ch;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        cyc   <= '0;
                    end else if (last) begin
                        cyc <= '0;
                        if (accept)
                            cur_ch <= in_ch;
                        else
                            state <= S_IDLE;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        stg_start = '0;
        if (run) begin
            for (int i = 0; i < NSTG; i++)
                stg_start[i] = (cyc == CYC_W'(stg_off(i, FRAME_CYCLES)));
        end
    end

    kf_state_bank #(
        .N    (N),
        .FRAC (FRAC),
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (done && ch_ok),
        .wr_ch   (cur_ch),
        .wr_data (nxt_state),
        .clr     (ch_clr),
        .clr_ch  (ch_clr_id),
        .rd_ch   (cur_ch),
        .rd_data (prv_state)
    );

endmodule

// File: tb/tb_kf_frame_seq_mc.sv
// Scoreboard bench for kf_frame_seq_mc (NCH=4 main DUT, NCH=5 range DUT).
module tb_kf_frame_seq_mc;

    localparam int W = 192;

`ifdef KF_SEQ_BACK2BACK_EN
    localparam int GAP = 36;
`else
    localparam int GAP = 37;
`endif

    localparam logic [W-1:0] RST = {
        16'h0100, 16'h0000, 16'h0000, 16'h0100,
        16'h0100, 16'h0000, 16'h0000, 16'h0100,
        16'h0100, 16'h0000, 16'h0000, 16'h0100};
    localparam logic [W-1:0] PAT_A = {12{16'hA5A1}};
    localparam logic [W-1:0] PAT_B = {12{16'h0B0B}};
    localparam logic [W-1:0] PAT_C = {12{16'h3C3C}};
    localparam logic [W-1:0] PAT_D = {12{16'hD00D}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_ch;
    logic         ch_clr;
    logic [1:0]   ch_clr_id;
    logic         abort;
    logic [7:0]   stg_start;
    logic [1:0]   cur_ch;
    logic [W-1:0] nxt_state;
    logic [W-1:0] prv_state;
    logic         done;
    logic [1:0]   done_ch;
    logic         busy;

    logic         in_valid5;
    logic         in_ready5;
    logic [2:0]   in_ch5;
    logic         zero5;
    logic [2:0]   clr_id5;
    logic [7:0]   stg_start5;
    logic [2:0]   cur_ch5;
    logic [W-1:0] prv_state5;
    logic         done5;
    logic [2:0]   done_ch5;
    logic         busy5;

    always #5 clk = ~clk;

    kf_frame_seq_mc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .ch_clr    (ch_clr),
        .ch_clr_id (ch_clr_id),
        .abort     (abort),
        .stg_start (stg_start),
        .cur_ch    (cur_ch),
        .nxt_state (nxt_state),
        .prv_state (prv_state),
        .done      (done),
        .done_ch   (done_ch),
        .busy      (busy)
    );

    kf_frame_seq_mc #(.NCH(5)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .in_ch     (in_ch5),
        .ch_clr    (zero5),
        .ch_clr_id (clr_id5),
        .abort     (zero5),
        .stg_start (stg_start5),
        .cur_ch    (cur_ch5),
        .nxt_state (nxt_state),
        .prv_state (prv_state5),
        .done      (done5),
        .done_ch   (done_ch5),
        .busy      (busy5)
    );

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct {
        int ch;
        int stamp;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] bank_m [4];
    int           checks = 0;
    int           failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic accept_next(input int ch, input bit exp_done,
                               output int stamp);
        int n;
        in_valid = 1'b1;
        in_ch    = 2'(ch);
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_wait", W'(in_ready), W'(1));
        stamp = cyc_n;
        if (exp_done)
            sb.push_back('{ch: ch, stamp: cyc_n + 36});
        @(negedge clk);
    endtask

    task automatic run_frame(input int ch, input bit chk_stg);
        int st;
        int pos [8];
        int cnt [8];
        int exp_pos [8];
        exp_pos = '{0, 0, 8, 10, 10, 12, 27, 27};
        for (int b = 0; b < 8; b++) begin
            pos[b] = -1;
            cnt[b] = 0;
        end
        accept_next(ch, 1'b1, st);
        in_valid = 1'b0;
        chk("prv_state", prv_state, bank_m[ch]);
        for (int k = 0; k < 36; k++) begin
            if (k > 0)
                @(negedge clk);
            for (int b = 0; b < 8; b++) begin
                if (stg_start[b]) begin
                    cnt[b]++;
                    pos[b] = k;
                end
            end
        end
        if (chk_stg) begin
            for (int b = 0; b < 8; b++)
                chk($sformatf("stg%0d_cyc", b),
                    W'((cnt[b] == 1) ? pos[b] : -1), W'(exp_pos[b]));
        end
        bank_m[ch] = nxt_state;
        @(negedge clk);
    endtask

    initial begin
        int st0, st1, st2, cnt, pos;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ch     = '0;
        ch_clr    = 1'b0;
        ch_clr_id = '0;
        abort     = 1'b0;
        nxt_state = PAT_A;
        in_valid5 = 1'b0;
        in_ch5    = '0;
        zero5     = 1'b0;
        clr_id5   = '0;
        for (int i = 0; i < 4; i++)
            bank_m[i] = RST;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (rst_n && done) begin
                        if (sb.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_done actual ch=%0d required=none",
                                     done_ch);
                        end else begin
                            e = sb.pop_front();
                            chk("done_ch", W'(done_ch), W'(e.ch));
                            chk("done_cycle", W'(cyc_n), W'(e.stamp));
                        end
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_stg", W'(stg_start), W'(0));
        chk("rst_cur_ch", W'(cur_ch), W'(0));
        chk("rst_done_ch", W'(done_ch), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // single frame on ch2 with stage timing, then bank contents
        nxt_state = PAT_A;
        run_frame(2, 1'b1);
        nxt_state = PAT_B;
        run_frame(2, 1'b0);
        run_frame(0, 1'b0);

        // held-valid sequence ch0, ch1, ch0
        nxt_state = PAT_C;
        accept_next(0, 1'b1, st0);
        accept_next(1, 1'b1, st1);
        accept_next(0, 1'b1, st2);
        in_valid = 1'b0;
        chk("gap01", W'(st1 - st0), W'(GAP));
        chk("gap12", W'(st2 - st1), W'(GAP));
        chk("b2b_prv_ch0", prv_state, PAT_C);
        repeat (36) @(negedge clk);
        bank_m[0] = PAT_C;
        bank_m[1] = PAT_C;

        // abort at cyc 20
        nxt_state = PAT_D;
        accept_next(3, 1'b0, st0);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_ready", W'(in_ready), W'(1));
        chk("abort_busy", W'(busy), W'(0));
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (stg_start != 8'h00)
                cnt++;
            @(negedge clk);
        end
        chk("abort_no_stg", W'(cnt), W'(0));
        run_frame(3, 1'b0);

        // clear coinciding with commit to ch1
        nxt_state = PAT_D;
        accept_next(1, 1'b1, st0);
        in_valid = 1'b0;
        repeat (35) @(negedge clk);
        ch_clr    = 1'b1;
        ch_clr_id = 2'd1;
        @(negedge clk);
        ch_clr = 1'b0;
        bank_m[1] = RST;
        accept_next(1, 1'b1, st0);
        in_valid = 1'b0;
        chk("clr_prv", prv_state, bank_m[1]);
        chk("clr_r11_one", W'(prv_state[191:176]), W'(16'h0100));
        repeat (35) @(negedge clk);
        bank_m[1] = nxt_state;
        @(negedge clk);

        // reset at cyc 15
        nxt_state = PAT_A;
        accept_next(0, 1'b0, st0);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", W'(busy), W'(0));
        chk("mrst_done", W'(done), W'(0));
        chk("mrst_stg", W'(stg_start), W'(0));
        chk("mrst_cur_ch", W'(cur_ch), W'(0));
        chk("mrst_done_ch", W'(done_ch), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            bank_m[i] = RST;
        @(negedge clk);
        run_frame(0, 1'b0);
        run_frame(2, 1'b0);

        // out-of-range channel on the 5-channel instance
        in_valid5 = 1'b1;
        in_ch5    = 3'd5;
        #1;
        chk("oor_in_ready", W'(in_ready5), W'(1));
        @(negedge clk);
        in_valid5 = 1'b0;
        cnt = 0;
        pos = -1;
        for (int k = 0; k < 40; k++) begin
            if (done5) begin
                cnt++;
                pos = k;
                chk("oor_done_ch", W'(done_ch5), W'(5));
            end
            @(negedge clk);
        end
        chk("oor_done_cnt", W'(cnt), W'(1));
        chk("oor_done_cyc", W'(pos), W'(35));
        in_valid5 = 1'b1;
        in_ch5    = 3'd4;
        #1;
        @(negedge clk);
        in_valid5 = 1'b0;
        chk("oor_bank4", prv_state5, RST);
        repeat (37) @(negedge clk);

        repeat (3) @(negedge clk);
        chk("sb_empty", W'(sb.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
